// File: rtl/cpu_axi_bridge_if.sv
// cpu_axi_bridge_if: AXI3 bus between the CPU bridge (master) and the
// crossbar/RAM (slave). Single-beat transfers only.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where both valid and ready are high. The source holds valid and the payload
// stable until that edge. The source never waits for ready before raising valid.
interface cpu_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // read address channel
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    // read data channel
    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    // write address channel
    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    // write data channel
    logic [3:0]        wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    // write response channel
    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: turns the core's inst and data SRAM-like ports into one
// AXI3 master. One read engine (shared by inst and data, data first) and one
// write engine, single-beat only. The data port keeps one transaction in
// flight so its data_ok pulses come back in request order.
//
// Optional build macro DATA_POSTED_WRITE_EN: a data write is acknowledged once
// its AW and W handshakes are done, and a later data read to a different word
// may start while the B response is still pending.
module cpu_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    // inst port (read-only)
    input  logic                inst_sram_req,
    input  logic                inst_sram_wr,
    input  logic [1:0]          inst_sram_size,
    input  logic [DATA_W/8-1:0] inst_sram_wstrb,
    input  logic [ADDR_W-1:0]   inst_sram_addr,
    input  logic [DATA_W-1:0]   inst_sram_wdata,
    output logic                inst_sram_addr_ok,
    output logic                inst_sram_data_ok,
    output logic [DATA_W-1:0]   inst_sram_rdata,
    // data port
    input  logic                data_sram_req,
    input  logic                data_sram_wr,
    input  logic [1:0]          data_sram_size,
    input  logic [DATA_W/8-1:0] data_sram_wstrb,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic                data_sram_addr_ok,
    output logic                data_sram_data_ok,
    output logic [DATA_W-1:0]   data_sram_rdata,
    // AXI3 master
    cpu_axi_bridge_if.master    axi,
    // FSM state observation
    output logic [1:0]          dbg_r_state,
    output logic [1:0]          dbg_w_state
);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_REQ  = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [1:0]        r_state, r_state_nxt;
    logic [1:0]        w_state, w_state_nxt;

    logic [3:0]        arid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [2:0]        arsize_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [2:0]        awsize_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              aw_done, w_done;

    logic r_idle, w_idle;
    logic data_rd_req, data_wr_req;
    logic data_rd_inflight;
    logic wr_blocks_rd;
    logic rd_sel_data, rd_sel_inst, wr_accept;
    logic aw_hs, w_hs, wr_issued;
    logic r_beat, b_beat, wr_data_ok;

    assign r_idle      = (r_state == R_IDLE);
    assign w_idle      = (w_state == W_IDLE);
    assign data_rd_req = data_sram_req & ~data_sram_wr;
    assign data_wr_req = data_sram_req &  data_sram_wr;

    // arid_q[0] marks the read in flight as a data read
    assign data_rd_inflight = ~r_idle & arid_q[0];

    assign aw_hs     = axi.awvalid & axi.awready;
    assign w_hs      = axi.wvalid  & axi.wready;
    assign wr_issued = (w_state == W_REQ) & (aw_done | aw_hs) & (w_done | w_hs);
    assign r_beat    = (r_state == R_DATA) & axi.rvalid;
    assign b_beat    = (w_state == W_RESP) & axi.bvalid;

`ifdef DATA_POSTED_WRITE_EN
    // a read may pass a write waiting on B unless it targets the same word
    assign wr_blocks_rd = (w_state == W_REQ) |
                          ((w_state == W_RESP) &
                           (data_sram_addr[ADDR_W-1:2] == awaddr_q[ADDR_W-1:2]));
    assign wr_data_ok   = wr_issued;
`else
    assign wr_blocks_rd = ~w_idle;
    assign wr_data_ok   = b_beat;
`endif

    // data read wins the read engine; a blocked data read lets inst through
    assign rd_sel_data = r_idle & data_rd_req & ~wr_blocks_rd;
    assign rd_sel_inst = r_idle & inst_sram_req & ~rd_sel_data;
    assign wr_accept   = w_idle & data_wr_req & ~data_rd_inflight;

    assign inst_sram_addr_ok = rd_sel_inst;
    assign data_sram_addr_ok = rd_sel_data | wr_accept;
    assign inst_sram_data_ok = r_beat & ~axi.rid[0];
    assign data_sram_data_ok = (r_beat & axi.rid[0]) | wr_data_ok;
    assign inst_sram_rdata   = axi.rdata;
    assign data_sram_rdata   = axi.rdata;

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = (r_state == R_ADDR);
    assign axi.rready  = (r_state == R_DATA);

    assign axi.awid    = 4'd1;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = awsize_q;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = (w_state == W_REQ) & ~aw_done;
    assign axi.wid     = 4'd1;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (w_state == W_REQ) & ~w_done;
    assign axi.bready  = (w_state == W_RESP);

    assign dbg_r_state = r_state;
    assign dbg_w_state = w_state;

    // inputs the bridge deliberately ignores
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             axi.rid[3:1], axi.rresp, axi.rlast, axi.bid, axi.bresp};

    // read FSM next state
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (rd_sel_data | rd_sel_inst) r_state_nxt = R_ADDR;
            R_ADDR:  if (axi.arready)               r_state_nxt = R_DATA;
            R_DATA:  if (axi.rvalid)                r_state_nxt = R_IDLE;
            default:                                r_state_nxt = R_IDLE;
        endcase
    end

    // write FSM next state
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (wr_accept)   w_state_nxt = W_REQ;
            W_REQ:   if (wr_issued)   w_state_nxt = W_RESP;
            W_RESP:  if (axi.bvalid)  w_state_nxt = W_IDLE;
            default:                  w_state_nxt = W_IDLE;
        endcase
    end

    // state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_state_nxt;
            w_state <= w_state_nxt;
        end
    end

    // AR payload, captured on the read addr_ok cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arid_q   <= 4'd0;
            araddr_q <= '0;
            arsize_q <= 3'd0;
        end else if (rd_sel_data) begin
            arid_q   <= 4'd1;
            araddr_q <= data_sram_addr;
            arsize_q <= {1'b0, data_sram_size};
        end else if (rd_sel_inst) begin
            arid_q   <= 4'd0;
            araddr_q <= inst_sram_addr;
            arsize_q <= {1'b0, inst_sram_size};
        end
    end

    // AW/W payload, captured on the write addr_ok cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awaddr_q <= '0;
            awsize_q <= 3'd0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (wr_accept) begin
            awaddr_q <= data_sram_addr;
            awsize_q <= {1'b0, data_sram_size};
            wdata_q  <= data_sram_wdata;
            wstrb_q  <= data_sram_wstrb;
        end
    end

    // AW and W complete independently; both flags clear when the pair is done
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (wr_issued) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end
endmodule
